// File: rtl/comp32_gt_monitor_if.sv
// Sample controls and registered statistics of the A>B flag monitor.
// The master side drives en/clr/z_in. The slave side (the monitor) returns the counters, pulse, alarm and state.
interface comp32_gt_monitor_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             clr;
    logic             z_in;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] max_run;
    logic             rise_pulse;
    logic             alarm;
    logic [1:0]       state;

    modport master (
        output en, clr, z_in,
        input  hit_cnt, run_len, max_run, rise_pulse, alarm, state
    );

    modport slave (
        input  en, clr, z_in,
        output hit_cnt, run_len, max_run, rise_pulse, alarm, state
    );
endinterface

// File: rtl/comp32_gt_monitor.sv
// Statistics on the sampled A>B flag: saturating hit count, run length, max run, rise pulse, sticky alarm.
// Latency: one clk from the sample edge to every output. No backpressure: a sample is taken on each en cycle.
// clr has priority over en and discards that cycle's sample.
module comp32_gt_monitor #(
    parameter int CNT_W     = 16,
    parameter int RUN_ALARM = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    comp32_gt_monitor_if.slave  mon
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOW  = 2'b01,
        HIGH = 2'b10,
        ALRM = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALARM_TH = CNT_W'(RUN_ALARM);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] hit_q, hit_nxt;
    logic [CNT_W-1:0] run_q, run_nxt;
    logic [CNT_W-1:0] max_q, max_nxt;
    logic             rise_q, rise_nxt;
    logic             alarm_q, alarm_nxt;
    logic [CNT_W-1:0] run_inc;
    logic             prev_z;

    // The last sampled z is implied by the state. IDLE and LOW both mean "no preceding 1".
    assign prev_z  = (state_q == HIGH) || (state_q == ALRM);
    assign run_inc = (run_q == CNT_MAX) ? run_q : run_q + ONE;

    always_comb begin
        state_nxt = state_q;
        hit_nxt   = hit_q;
        run_nxt   = run_q;
        max_nxt   = max_q;
        alarm_nxt = alarm_q;
        rise_nxt  = 1'b0;
        if (mon.clr) begin
            state_nxt = IDLE;
            hit_nxt   = '0;
            run_nxt   = '0;
            max_nxt   = '0;
            alarm_nxt = 1'b0;
        end else if (mon.en) begin
            if (mon.z_in) begin
                hit_nxt  = (hit_q == CNT_MAX) ? hit_q : hit_q + ONE;
                run_nxt  = run_inc;
                rise_nxt = ~prev_z;
                if (run_inc > max_q) max_nxt = run_inc;
                case (state_q)
                    ALRM:    state_nxt = ALRM;
                    default: state_nxt = (run_inc >= ALARM_TH) ? ALRM : HIGH;
                endcase
                if (state_nxt == ALRM) alarm_nxt = 1'b1;
            end else begin
                run_nxt   = '0;
                state_nxt = LOW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hit_q   <= '0;
            run_q   <= '0;
            max_q   <= '0;
            rise_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            hit_q   <= hit_nxt;
            run_q   <= run_nxt;
            max_q   <= max_nxt;
            rise_q  <= rise_nxt;
            alarm_q <= alarm_nxt;
        end
    end

    assign mon.hit_cnt    = hit_q;
    assign mon.run_len    = run_q;
    assign mon.max_run    = max_q;
    assign mon.rise_pulse = rise_q;
    assign mon.alarm      = alarm_q;
    assign mon.state      = state_q;
endmodule

// File: tb/tb_comp32_gt_monitor.sv
// Two monitors (16-bit/alarm 4 and 4-bit/alarm 1) share one stimulus stream.
// Both are checked against a per-sample arithmetic model of the statistics.
module tb_comp32_gt_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comp32_gt_monitor_if #(.CNT_W(16)) if_a ();
    comp32_gt_monitor_if #(.CNT_W(4))  if_b ();

    comp32_gt_monitor #(.CNT_W(16), .RUN_ALARM(4)) dut_a (.clk(clk), .rst_n(rst_n), .mon(if_a));
    comp32_gt_monitor #(.CNT_W(4),  .RUN_ALARM(1)) dut_b (.clk(clk), .rst_n(rst_n), .mon(if_b));

    int checks = 0;
    int errors = 0;

    // Reference model: plain counts, capped at each instance's maximum.
    int cap [2] = '{65535, 15};
    int thr [2] = '{4, 1};
    int hits[2], run[2], maxr[2];
    bit prev[2], alm[2], rise[2], sampled[2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            hits[i] = 0; run[i] = 0; maxr[i] = 0;
            prev[i] = 0; alm[i] = 0; rise[i] = 0; sampled[i] = 0;
        end
    endtask

    task automatic model_edge(input bit e, input bit c, input bit z);
        for (int i = 0; i < 2; i++) begin
            rise[i] = 0;
            if (c) begin
                hits[i] = 0; run[i] = 0; maxr[i] = 0;
                prev[i] = 0; alm[i] = 0; sampled[i] = 0;
            end else if (e) begin
                if (z) begin
                    hits[i] = (hits[i] + 1 > cap[i]) ? cap[i] : hits[i] + 1;
                    run[i]  = (run[i] + 1 > cap[i]) ? cap[i] : run[i] + 1;
                    if (run[i] > maxr[i]) maxr[i] = run[i];
                    rise[i] = !prev[i];
                    if (run[i] >= thr[i]) alm[i] = 1;
                end else begin
                    run[i] = 0;
                end
                prev[i]    = z;
                sampled[i] = 1;
            end
        end
    endtask

    function automatic int exp_state(input int i);
        if (!sampled[i]) return 0;
        if (!prev[i]) return 1;
        return (run[i] >= thr[i]) ? 3 : 2;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string tag, input int i, input int h, input int r,
                             input int m, input int p, input int a, input int s);
        check($sformatf("%s_%0d_hit", tag, i),   h, hits[i]);
        check($sformatf("%s_%0d_run", tag, i),   r, run[i]);
        check($sformatf("%s_%0d_max", tag, i),   m, maxr[i]);
        check($sformatf("%s_%0d_rise", tag, i),  p, int'(rise[i]));
        check($sformatf("%s_%0d_alarm", tag, i), a, int'(alm[i]));
        check($sformatf("%s_%0d_state", tag, i), s, exp_state(i));
    endtask

    task automatic check_all(input string tag);
        check_one(tag, 0, int'(if_a.hit_cnt), int'(if_a.run_len), int'(if_a.max_run),
                  int'(if_a.rise_pulse), int'(if_a.alarm), int'(if_a.state));
        check_one(tag, 1, int'(if_b.hit_cnt), int'(if_b.run_len), int'(if_b.max_run),
                  int'(if_b.rise_pulse), int'(if_b.alarm), int'(if_b.state));
    endtask

    // Apply inputs, let one rising edge take them, then compare 1 time unit later.
    task automatic step(input string tag, input bit e, input bit c, input bit z);
        if_a.en = e; if_a.clr = c; if_a.z_in = z;
        if_b.en = e; if_b.clr = c; if_b.z_in = z;
        @(posedge clk);
        model_edge(e, c, z);
        #1;
        check_all(tag);
    endtask

    initial begin
        if_a.en = 0; if_a.clr = 0; if_a.z_in = 0;
        if_b.en = 0; if_b.clr = 0; if_b.z_in = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_all("rst_init");
        @(negedge clk) rst_n = 1'b1;

        // T1: asynchronous reset while a run of 3 is in progress
        for (int k = 0; k < 3; k++) step("t1_run", 1, 0, 1);
        check("t1_run_len3", int'(if_a.run_len), 3);
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_all("t1_async");
        @(negedge clk) rst_n = 1'b1;

        // T2: z = 0,1,1,0,1
        step("t2_s1", 1, 0, 0);
        step("t2_s2", 1, 0, 1);
        check("t2_rise2", int'(if_a.rise_pulse), 1);
        step("t2_s3", 1, 0, 1);
        step("t2_s4", 1, 0, 0);
        step("t2_s5", 1, 0, 1);
        check("t2_rise5", int'(if_a.rise_pulse), 1);
        check("t2_hit", int'(if_a.hit_cnt), 3);
        check("t2_run", int'(if_a.run_len), 1);
        check("t2_max", int'(if_a.max_run), 2);
        check("t2_alarm", int'(if_a.alarm), 0);

        // T3: alarm on the 4th consecutive 1, sticky through a 0, cleared by clr
        step("t3_clr", 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step("t3_hi", 1, 0, 1);
            if (k == 4) begin
                check("t3_state4", int'(if_a.state), 3);
                check("t3_alarm4", int'(if_a.alarm), 1);
            end
        end
        step("t3_lo", 1, 0, 0);
        check("t3_state_lo", int'(if_a.state), 1);
        check("t3_alarm_lo", int'(if_a.alarm), 1);
        step("t3_clr2", 0, 1, 0);
        check("t3_alarm_clr", int'(if_a.alarm), 0);
        check("t3_state_clr", int'(if_a.state), 0);

        // T4: en gating with z toggling underneath
        step("t4_a", 1, 0, 1);
        for (int k = 0; k < 3; k++) step("t4_gap", 0, 0, k[0]);
        step("t4_b", 1, 0, 1);
        check("t4_run", int'(if_a.run_len), 2);
        check("t4_hit", int'(if_a.hit_cnt), 2);
        check("t4_norise", int'(if_a.rise_pulse), 0);

        // T5: clr and en together discard the sample
        step("t5_both", 1, 1, 1);
        check("t5_hit0", int'(if_a.hit_cnt), 0);
        step("t5_next", 1, 0, 1);
        check("t5_rise", int'(if_a.rise_pulse), 1);
        check("t5_hit1", int'(if_a.hit_cnt), 1);

        // T6: 20 ones saturate the 4-bit instance at 15
        step("t6_clr", 0, 1, 0);
        for (int k = 0; k < 20; k++) step("t6_hi", 1, 0, 1);
        check("t6_hit15", int'(if_b.hit_cnt), 15);
        check("t6_run15", int'(if_b.run_len), 15);
        check("t6_max15", int'(if_b.max_run), 15);
        step("t6_lo", 1, 0, 0);
        check("t6_run0", int'(if_b.run_len), 0);
        check("t6_maxhold", int'(if_b.max_run), 15);

        // Randomized traffic with occasional clears
        for (int k = 0; k < 400; k++) begin
            step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
